// File: rtl/leaf_pkt_pkg.sv
// Default field widths and constants for leaf-to-BFT packets.
// The packet layout is {valid, dest leaf, dest port, addr, payload}, with valid in the MSB.
package leaf_pkt_pkg;

    localparam int unsigned PKT_PAYLOAD_BITS          = 32;
    localparam int unsigned PKT_NUM_LEAF_BITS         = 5;
    localparam int unsigned PKT_NUM_PORT_BITS         = 4;
    localparam int unsigned PKT_NUM_ADDR_BITS         = 7;
    localparam int unsigned PKT_PACKET_BITS           = 1 + PKT_NUM_LEAF_BITS + PKT_NUM_PORT_BITS
                                                        + PKT_NUM_ADDR_BITS + PKT_PAYLOAD_BITS;
    localparam int unsigned PKT_FREESPACE_UPDATE_SIZE = 64;

    // Field offsets within a packet of the default widths.
    localparam int unsigned ADDR_LSB  = PKT_PAYLOAD_BITS;
    localparam int unsigned PORT_LSB  = ADDR_LSB + PKT_NUM_ADDR_BITS;
    localparam int unsigned LEAF_LSB  = PORT_LSB + PKT_NUM_PORT_BITS;
    localparam int unsigned VALID_BIT = PKT_PACKET_BITS - 1;

    // A receiver holds one word per address, so a full window is 2**addr_bits credits.
    localparam int unsigned PKT_CREDIT_MAX = 1 << PKT_NUM_ADDR_BITS;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// It grants the first request at or after ptr and wraps past N-1.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any_grant
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt       = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((32'(ptr) + 32'(k)) % N);
            if (!any_grant && req[idx]) begin
                gnt[idx]  = 1'b1;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Arbitrates user output streams onto the single leaf-to-BFT packet register.
// Arbitration is round-robin, and each port is gated by its credits and by its route-table entry.
module leaf_out_arbiter
    import leaf_pkt_pkg::*;
#(
    parameter int unsigned PACKET_BITS           = PKT_PACKET_BITS,
    parameter int unsigned PAYLOAD_BITS          = PKT_PAYLOAD_BITS,
    parameter int unsigned NUM_LEAF_BITS         = PKT_NUM_LEAF_BITS,
    parameter int unsigned NUM_PORT_BITS         = PKT_NUM_PORT_BITS,
    parameter int unsigned NUM_ADDR_BITS         = PKT_NUM_ADDR_BITS,
    parameter int unsigned NUM_OUT_PORTS         = 3,
    parameter int unsigned FREESPACE_UPDATE_SIZE = PKT_FREESPACE_UPDATE_SIZE
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    resend,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
    input  logic                                    credit_vld,
    input  logic [NUM_PORT_BITS-1:0]                credit_port,
    output logic [PACKET_BITS-1:0]                  pkt_out,
    input  logic                                    pkt_rdy
);

    localparam int unsigned N          = NUM_OUT_PORTS;
    localparam int unsigned PTR_W      = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW         = NUM_ADDR_BITS + 1;
    localparam int unsigned CREDIT_MAX = 1 << NUM_ADDR_BITS;
    localparam int unsigned VLD        = PACKET_BITS - 1;

    logic [NUM_LEAF_BITS-1:0] leaf_q   [N];
    logic [NUM_PORT_BITS-1:0] port_q   [N];
    logic [CW-1:0]            credit_q [N];
    logic [CW-1:0]            credit_d [N];
    logic [CW:0]              csum     [N];
    logic [NUM_ADDR_BITS-1:0] addr_q   [N];
    logic [NUM_ADDR_BITS-1:0] addr_d   [N];
    logic [N-1:0]             cfg_q;
    logic [N-1:0]             cfg_hit;
    logic [N-1:0]             elig;
    logic [N-1:0]             req;
    logic [N-1:0]             gnt;
    logic                     any_gnt;
    logic                     reg_free;
    logic [PTR_W-1:0]         gnt_idx;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

    always_comb begin
        elig    = '0;
        cfg_hit = '0;
        for (int i = 0; i < N; i++) begin
            elig[i]    = vld_user2interface[i] & cfg_q[i] & (credit_q[i] != '0) & ~resend;
            cfg_hit[i] = cfg_wr && (cfg_port == NUM_PORT_BITS'(i));
        end
    end

    assign reg_free = ~pkt_q[VLD] | pkt_rdy;
    assign req      = reg_free ? elig : '0;

    rr_arbiter #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (req),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .any_grant (any_gnt)
    );

    assign ack_interface2user = gnt;
    assign pkt_out            = pkt_q;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    // The grant always uses the route as it stood before any same-cycle cfg write.
    always_comb begin
        pkt_d = pkt_q;
        if (reg_free && !resend) begin
            pkt_d = '0;
            if (any_gnt) begin
                pkt_d = {1'b1, leaf_q[gnt_idx], port_q[gnt_idx], addr_q[gnt_idx],
                         din_leaf_user2interface[gnt_idx*PAYLOAD_BITS +: PAYLOAD_BITS]};
            end
        end
    end

    // Credits are consumed first, then returned and saturated, and a cfg write overrides both.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            csum[i] = {1'b0, credit_q[i]} - {{CW{1'b0}}, gnt[i]};
            if (credit_vld && (credit_port == NUM_PORT_BITS'(i))) begin
                csum[i] = csum[i] + (CW+1)'(FREESPACE_UPDATE_SIZE);
                if (csum[i] > (CW+1)'(CREDIT_MAX)) begin
                    csum[i] = (CW+1)'(CREDIT_MAX);
                end
            end
            addr_d[i] = addr_q[i] + NUM_ADDR_BITS'(gnt[i]);
            if (cfg_hit[i]) begin
                csum[i]   = (CW+1)'(CREDIT_MAX);
                addr_d[i] = '0;
            end
            credit_d[i] = csum[i][CW-1:0];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) begin
            ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q <= '0;
            ptr_q <= '0;
            cfg_q <= '0;
            for (int i = 0; i < N; i++) begin
                leaf_q[i]   <= '0;
                port_q[i]   <= '0;
                credit_q[i] <= '0;
                addr_q[i]   <= '0;
            end
        end else begin
            pkt_q <= pkt_d;
            ptr_q <= ptr_d;
            for (int i = 0; i < N; i++) begin
                credit_q[i] <= credit_d[i];
                addr_q[i]   <= addr_d[i];
                if (cfg_hit[i]) begin
                    leaf_q[i] <= cfg_dest_leaf;
                    port_q[i] <= cfg_dest_port;
                    cfg_q[i]  <= 1'b1;
                end
            end
        end
    end

endmodule
